prog_loader: RTL and testbench

PROG_LOADER -- requirements
Module: prog_loader

---
 rtl/prog_loader_pkg.sv | 17 +
 rtl/byte_packer.sv | 44 ++++
 rtl/prog_loader.sv | 139 +++++++++++++
 tb/tb_prog_loader.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/prog_loader_pkg.sv
// Shared types for the program loader.
// State encoding and counter widths.
package prog_loader_pkg;

  localparam int BCNT_W = 2;
  localparam int WIDX_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RECV,
    ST_WRITE,
    ST_CHECK,
    ST_RUN,
    ST_ERROR
  } state_e;

endpackage

// File: rtl/byte_packer.sv
// Big-endian byte-to-word packer.
// full flags the shift that completes a word.
module byte_packer
  import prog_loader_pkg::*;
(
  input  logic        clk,
  input  logic        clr_n,
  input  logic        clr,
  input  logic        shift,
  input  logic [7:0]  din,
  output logic [31:0] word,
  output logic        full
);

  logic [BCNT_W-1:0] cnt_q, cnt_d;
  logic [23:0]       data_q, data_d;

  // The fourth byte is taken straight from din so the word is ready on its cycle.
  assign word = {data_q, din};
  assign full = shift && (cnt_q == '1);

  always_comb begin
    cnt_d  = cnt_q;
    data_d = data_q;
    if (clr) begin
      cnt_d  = '0;
      data_d = '0;
    end else if (shift) begin
      cnt_d  = cnt_q + 1'b1;
      data_d = {data_q[15:0], din};
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      cnt_q  <= '0;
      data_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      data_q <= data_d;
    end
  end

endmodule

// File: rtl/prog_loader.sv
// Streams a program into instruction memory, verifies
// an XOR checksum, then releases the CPU pipeline.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          MAX_WORDS = 256
) (
  input  logic        clk,
  input  logic        clr_n,
  input  logic        start,
  input  logic [15:0] len_words,
  input  logic        s_valid,
  input  logic [7:0]  s_data,
  output logic        s_ready,
  output logic        im_we,
  output logic [31:0] im_addr,
  output logic [31:0] im_wdata,
  output logic        cpu_clr_n,
  output logic        cpu_en,
  output logic        done,
  output logic        err
);

  state_e            state_q, state_d;
  logic [WIDX_W-1:0] idx_q, idx_d;
  logic [WIDX_W-1:0] last_q, last_d;
  logic [7:0]        csum_q, csum_d;
  logic [31:0]       addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              done_q, done_d;

  logic        accept;
  logic        len_ok;
  logic        pk_clr;
  logic        pk_shift;
  logic [31:0] pk_word;
  logic        pk_full;

  assign s_ready   = (state_q == ST_RECV) || (state_q == ST_CHECK);
  assign accept    = s_valid && s_ready;
  assign im_we     = (state_q == ST_WRITE);
  assign im_addr   = addr_q;
  assign im_wdata  = wdata_q;
  assign cpu_en    = (state_q == ST_RUN);
  assign cpu_clr_n = (state_q == ST_RUN);
  assign err       = (state_q == ST_ERROR);
  assign done      = done_q;

  assign len_ok = (len_words != '0) &&
                  ({16'h0, len_words} <= 32'(MAX_WORDS));
  assign pk_shift = (state_q == ST_RECV) && accept;

  byte_packer u_packer (
    .clk   (clk),
    .clr_n (clr_n),
    .clr   (pk_clr),
    .shift (pk_shift),
    .din   (s_data),
    .word  (pk_word),
    .full  (pk_full)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    last_d  = last_q;
    csum_d  = csum_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    done_d  = 1'b0;
    pk_clr  = 1'b0;
    case (state_q)
      ST_IDLE, ST_RUN, ST_ERROR: begin
        if (start) begin
          pk_clr = 1'b1;
          if (len_ok) begin
            state_d = ST_RECV;
            idx_d   = '0;
            csum_d  = 8'h00;
            last_d  = len_words - 16'd1;
          end else begin
            state_d = ST_ERROR;
          end
        end
      end
      ST_RECV: begin
        if (accept) begin
          csum_d = csum_q ^ s_data;
          if (pk_full) begin
            state_d = ST_WRITE;
            addr_d  = BASE_ADDR + 32'({idx_q, 2'b00});
            wdata_d = pk_word;
          end
        end
      end
      ST_WRITE: begin
        if (idx_q == last_q) begin
          state_d = ST_CHECK;
        end else begin
          state_d = ST_RECV;
          idx_d   = idx_q + 1'b1;
        end
      end
      ST_CHECK: begin
        if (accept) begin
          if (s_data == csum_q) begin
            state_d = ST_RUN;
            done_d  = 1'b1;
          end else begin
            state_d = ST_ERROR;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      last_q  <= '0;
      csum_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
      csum_q  <= csum_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      done_q  <= done_d;
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Randomized bench for prog_loader against a byte-array model;
// two instances cover base address 0 and the wrap-around base.
module tb_prog_loader;

  logic        clk = 1'b0;
  logic        clr_n;
  logic        start;
  logic [15:0] len_words;
  logic        s_valid;
  logic [7:0]  s_data;

  logic        rdy [2];
  logic        we  [2];
  logic [31:0] addr[2];
  logic [31:0] wdat[2];
  logic        cclr[2];
  logic        cen [2];
  logic        dn  [2];
  logic        er  [2];

  prog_loader #(.BASE_ADDR(32'h0000_0000), .MAX_WORDS(256)) u_dut0 (
    .clk(clk), .clr_n(clr_n), .start(start), .len_words(len_words),
    .s_valid(s_valid), .s_data(s_data), .s_ready(rdy[0]),
    .im_we(we[0]), .im_addr(addr[0]), .im_wdata(wdat[0]),
    .cpu_clr_n(cclr[0]), .cpu_en(cen[0]), .done(dn[0]), .err(er[0])
  );

  prog_loader #(.BASE_ADDR(32'hFFFF_FFFC), .MAX_WORDS(256)) u_dut1 (
    .clk(clk), .clr_n(clr_n), .start(start), .len_words(len_words),
    .s_valid(s_valid), .s_data(s_data), .s_ready(rdy[1]),
    .im_we(we[1]), .im_addr(addr[1]), .im_wdata(wdat[1]),
    .cpu_clr_n(cclr[1]), .cpu_en(cen[1]), .done(dn[1]), .err(er[1])
  );

  always #5 clk = ~clk;

  int n_chk;
  int n_pass;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Write monitor and timing observers
  logic [31:0] wa0[$], wd0[$], wa1[$], wd1[$];
  int cyc, last_acc, lat_err, rdy_we_err, done_cnt;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (s_valid && rdy[0]) last_acc <= cyc;
    if (we[0]) begin
      wa0.push_back(addr[0]);
      wd0.push_back(wdat[0]);
      if (last_acc != cyc - 1) lat_err <= lat_err + 1;
      if (rdy[0]) rdy_we_err <= rdy_we_err + 1;
    end
    if (we[1]) begin
      wa1.push_back(addr[1]);
      wd1.push_back(wdat[1]);
    end
    if (dn[0]) done_cnt <= done_cnt + 1;
  end

  logic [7:0] bytes[$];

  task automatic clear_log();
    wa0.delete(); wd0.delete(); wa1.delete(); wd1.delete();
  endtask

  task automatic pulse_start(input int l);
    start = 1'b1;
    len_words = 16'(l);
    @(posedge clk); #1;
    start = 1'b0;
    len_words = 16'($urandom);
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    bit acc = 1'b0;
    s_valid = 1'b1;
    s_data = b;
    for (int k = 0; k < 64 && !acc; k++) begin
      @(negedge clk);
      acc = rdy[0];
      @(posedge clk); #1;
    end
    s_valid = 1'b0;
    s_data = 8'($urandom);
    if (!acc) check("accept_timeout", 32'd0, 32'd1);
    repeat (gap) begin @(posedge clk); #1; end
  endtask

  task automatic check_reset_vals(input string t);
    check({t, "_s_ready"}, 32'(rdy[0]), 32'd0);
    check({t, "_im_we"}, 32'(we[0]), 32'd0);
    check({t, "_im_addr"}, addr[0], 32'd0);
    check({t, "_im_wdata"}, wdat[0], 32'd0);
    check({t, "_cpu"}, {30'd0, cclr[0], cen[0]}, 32'd0);
    check({t, "_done_err"}, {30'd0, dn[0], er[0]}, 32'd0);
    check({t, "_dut1"}, {rdy[1], we[1], cclr[1], cen[1], dn[1], er[1],
                         26'd0} | addr[1], 32'd0);
  endtask

  // Model: words are bytes taken four at a time, first byte most
  // significant; checksum is the XOR of every program byte.
  task automatic run_load(input int len, input logic [7:0] xmask,
                          input int gmin, input int gmax,
                          input bit inj_start);
    logic [7:0]  cs;
    logic [31:0] w;
    int          dc0;
    bit          good;
    int          n;
    cs = 8'h00;
    foreach (bytes[i]) cs ^= bytes[i];
    good = (xmask == 8'h00);
    clear_log();
    dc0 = done_cnt;
    pulse_start(len);
    for (int i = 0; i < 4 * len; i++) begin
      if (inj_start && i == 1) pulse_start(0);
      send_byte(bytes[i], $urandom_range(gmax, gmin));
    end
    send_byte(cs ^ xmask, 0);
    check("done", 32'(dn[0]), 32'(good));
    check("cpu_en", 32'(cen[0]), 32'(good));
    check("cpu_clr_n", 32'(cclr[0]), 32'(good));
    check("err", 32'(er[0]), 32'(!good));
    check("dut1_out", {29'd0, dn[1], cen[1], er[1]},
          {29'd0, good, good, !good});
    check("nwrites", 32'(wa0.size()), 32'(len));
    check("nwrites1", 32'(wa1.size()), 32'(len));
    n = (wa0.size() < len) ? wa0.size() : len;
    if (wa1.size() < n) n = wa1.size();
    for (int i = 0; i < n; i++) begin
      w = {bytes[4*i], bytes[4*i+1], bytes[4*i+2], bytes[4*i+3]};
      check("waddr0", wa0[i], 32'(4 * i));
      check("wdata0", wd0[i], w);
      check("waddr1", wa1[i], 32'hFFFF_FFFC + 32'(4 * i));
      check("wdata1", wd1[i], w);
    end
    @(posedge clk); #1;
    check("done_pulse", 32'(dn[0]), 32'd0);
    check("done_count", 32'(done_cnt - dc0), 32'(good));
    check("hold_state", {29'd0, cen[0], cclr[0], er[0]},
          {29'd0, good, good, !good});
  endtask

  task automatic rand_bytes(input int len);
    bytes.delete();
    for (int i = 0; i < 4 * len; i++) bytes.push_back(8'($urandom));
  endtask

  initial begin
    clr_n = 1'b0;
    start = 1'b0;
    s_valid = 1'b0;
    len_words = 16'd0;
    s_data = 8'd0;
    #12;
    check_reset_vals("rst");
    @(negedge clk);
    clr_n = 1'b1;
    @(posedge clk); #1;
    check_reset_vals("idle");

    // Known vector, good checksum 2D
    bytes = '{8'h20, 8'h08, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h00};
    run_load(2, 8'h00, 0, 0, 0);

    // Zero length from RUN
    clear_log();
    pulse_start(0);
    check("len0_err", {30'd0, er[0], cen[0]}, 32'd2);
    repeat (3) begin @(posedge clk); #1; end
    check("len0_nowrite", 32'(wa0.size()), 32'd0);

    // Same vector, checksum 2C
    bytes = '{8'h20, 8'h08, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h00};
    run_load(2, 8'h01, 0, 0, 0);
    repeat (5) begin @(posedge clk); #1; end
    check("err_sticky", {30'd0, er[0], cclr[0]}, 32'd2);

    // One word with s_valid toggling every cycle
    rand_bytes(1);
    run_load(1, 8'h00, 1, 1, 0);

    // Asynchronous reset mid-load
    rand_bytes(2);
    clear_log();
    pulse_start(2);
    for (int i = 0; i < 6; i++) send_byte(bytes[i], 0);
    #2 clr_n = 1'b0;
    #1 check_reset_vals("midrst");
    check("midrst_writes", 32'(wa0.size()), 32'd1);
    @(negedge clk);
    clr_n = 1'b1;
    @(posedge clk); #1;
    rand_bytes(3);
    run_load(3, 8'h00, 0, 1, 0);

    // Length bounds
    pulse_start(257);
    check("len257_err", 32'(er[0]), 32'd1);
    rand_bytes(256);
    run_load(256, 8'h00, 0, 0, 0);

    // Randomized loads
    for (int t = 0; t < 12; t++) begin
      int l;
      logic [7:0] m;
      l = $urandom_range(24, 1);
      m = ($urandom_range(3) == 0) ? 8'(1 << $urandom_range(7)) : 8'h00;
      rand_bytes(l);
      run_load(l, m, 0, 2, 1'($urandom_range(1)));
    end

    check("write_latency", 32'(lat_err), 32'd0);
    check("ready_in_write", 32'(rdy_we_err), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
